shufflenetv2_mul_pipe: RTL and testbench
========================================

SHUFFLENETV2_MUL_PIPE -- requirements
Module: shufflenetv2_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 12, operand A width (2..27).
REQ-002 SHALL have parameter DIN1_WIDTH, default 10, operand B width (2..18).
REQ-003 SHALL have parameter DOUT_WIDTH, default 22, result width (1..DIN0_WIDTH+DIN1_WIDTH).
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth in cycles (1..6).
REQ-005 SHALL have parameters SIGNED0 and SIGNED1, default 0, each 1 = that operand is two's complement.
REQ-006 SHALL have parameter FRAC_BITS, default 0, right-shift applied to the product (0..DIN0_WIDTH+DIN1_WIDTH-1).
REQ-007 SHALL have parameter SATURATE, default 0: 1 = clamp to DOUT range, 0 = keep low DOUT_WIDTH bits.
REQ-008 Ports: clk  in  1  clock; one clock domain, all state changes on its rising edge.
REQ-009 Ports: reset  in  1  synchronous, active-high reset.
REQ-010 Ports: din0  in  DIN0_WIDTH  operand A; din1  in  DIN1_WIDTH  operand B.
REQ-011 Ports: in_valid  in  1; in_ready  out  1  input handshake.
REQ-012 Ports: dout  out  DOUT_WIDTH  result; ovf  out  1  result was clamped or truncated with loss.
REQ-013 Ports: out_valid  out  1; out_ready  in  1  output handshake.

Function
REQ-014 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-015 Pipeline advance enable adv = !out_valid | out_ready; all stages shift together only when adv = 1.
REQ-016 in_ready SHALL equal adv (combinational); no skid buffer.
REQ-017 Latency: an accepted beat appears on dout/out_valid exactly NUM_STAGE edges later when no stall occurs; each stall cycle adds one cycle.
REQ-018 Throughput: one beat per cycle while out_ready = 1.
REQ-019 Per-stage valid bit travels with data; bubbles (in_valid = 0) SHALL propagate as invalid stages and never produce out_valid.
REQ-020 While out_valid = 1 and out_ready = 0, dout, ovf and out_valid SHALL hold stable.
REQ-021 Product P is full-width DIN0_WIDTH+DIN1_WIDTH; an operand is sign-extended when its SIGNEDx = 1, else zero-extended; the result is signed if SIGNED0 or SIGNED1.
REQ-022 If FRAC_BITS > 0, R = (P + 2^(FRAC_BITS-1)) shifted right by FRAC_BITS (arithmetic if signed): round half up toward +inf; if FRAC_BITS = 0, R = P.
REQ-023 SATURATE = 1: R above the DOUT maximum gives the maximum, below the minimum gives the minimum, and ovf = 1; otherwise dout = R and ovf = 0.
REQ-024 SATURATE = 0: dout = R[DOUT_WIDTH-1:0]; ovf = 1 iff the discarded upper bits are not a pure sign/zero extension of dout.
REQ-025 The rounding addition SHALL NOT overflow: it is carried at one extra bit.
REQ-026 The multiply SHALL occupy stage 1 and round/saturate the last stage; when NUM_STAGE = 1 both SHALL be in one stage.

Reset
REQ-027 While reset = 1: all stage valid bits SHALL clear; out_valid = 0, dout = 0, ovf = 0 on the next edge.
REQ-028 in_ready SHALL read 1 during and after reset; beats presented on a reset edge SHALL be discarded.
REQ-029 Reset mid-stream SHALL drop all in-flight beats; no partial result SHALL emerge afterwards.

Structure
REQ-030 Package shufflenetv2_mul_pkg SHALL hold the product-width and min/max constant functions used for saturation bounds.
REQ-031 The combinational round/saturate logic SHALL be one sub-module, shufflenetv2_mul_round_sat; the stage registers and handshake stay in the top.
REQ-032 With default parameters and out_ready tied to 1, results SHALL equal the plain unsigned 12x10 product, delayed by NUM_STAGE cycles.

Verification
REQ-033 Defaults: din0 = 4095, din1 = 1023, out_ready = 1 -> dout = 4189185, ovf = 0, exactly 3 cycles later.
REQ-034 8x8 signed, DOUT = 8, FRAC_BITS = 4, SATURATE = 1: inputs (3,3) (5,5) (-3,3) (-128,-128) -> results 1, 2, -1, 127 with ovf = 1 on the last result only.
REQ-035 Same config, SATURATE = 0: (-128,-128) -> dout = 0x00 (1024 truncated), ovf = 1.
REQ-036 Stream of 16 beats with out_ready toggled in a random pattern -> every beat output once, in order, with stable dout during stalls and in_ready = 0 whenever out_valid & !out_ready.
REQ-037 Assert reset with 2 beats in flight -> out_valid stays 0 for the following NUM_STAGE cycles and the first post-reset beat emerges alone.
REQ-038 NUM_STAGE = 1, alternating in_valid -> out_valid alternates one cycle later and no extra beats appear.

Source files
------------

// File: rtl/shufflenetv2_mul_pkg.sv
// Shared sizing helpers for the pipelined multiplier: product width and result range bounds.
// Pure constant functions, no logic.
// Not applicable (no handshake).
package shufflenetv2_mul_pkg;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic logic signed [63:0] out_max(input int w, input bit sgn);
        return sgn ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] out_min(input int w, input bit sgn);
        return sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/shufflenetv2_mul_round_sat.sv
// Rounds the full-width product by FRAC_BITS and clamps or truncates it to DOUT_WIDTH.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline stage owns flow control.
module shufflenetv2_mul_round_sat
    import shufflenetv2_mul_pkg::*;
#(
    parameter int PW         = 22,
    parameter int DOUT_WIDTH = 22,
    parameter bit RES_SIGNED = 1'b0,
    parameter int FRAC_BITS  = 0,
    parameter int SATURATE   = 0
) (
    input  logic [PW-1:0]         prod,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);
    // Two guard bits: one for unsigned-as-signed, one so the rounding add cannot wrap.
    localparam int SW = PW + 2;
    localparam logic signed [63:0] MAXV = out_max(DOUT_WIDTH, RES_SIGNED);
    localparam logic signed [63:0] MINV = out_min(DOUT_WIDTH, RES_SIGNED);
    localparam logic [SW-1:0] HALF = (SW'(1) << FRAC_BITS) >> 1;

    logic signed [SW-1:0] p_w;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] r;
    logic signed [63:0]   r64;
    logic                 hi;
    logic                 lo;

    always_comb begin
        p_w  = {{2{RES_SIGNED && prod[PW-1]}}, prod};
        sum  = p_w + HALF;
        r    = sum >>> FRAC_BITS;
        r64  = {{(64-SW){r[SW-1]}}, r};
        hi   = r64 > MAXV;
        lo   = r64 < MINV;
        // Out of range is exactly "upper bits are not an extension of dout", so one test serves both modes.
        ovf  = hi || lo;
        dout = r[DOUT_WIDTH-1:0];
        if (SATURATE != 0 && hi) begin
            dout = MAXV[DOUT_WIDTH-1:0];
        end else if (SATURATE != 0 && lo) begin
            dout = MINV[DOUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/shufflenetv2_mul_pipe.sv
// Pipelined multiplier with rounding and optional saturation.
// Latency NUM_STAGE cycles; multiply in the first stage, round/saturate into the last.
// Whole pipe stalls together when the output is held; in_ready = !out_valid | out_ready.
module shufflenetv2_mul_pipe
    import shufflenetv2_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 12,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 22,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int FRAC_BITS  = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam bit RES_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);

    logic                  adv;
    logic [NUM_STAGE-1:0]  vld;
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;
    logic [PW-1:0]         prod_c;
    logic [PW-1:0]         rs_prod;
    logic [DOUT_WIDTH-1:0] rs_dout;
    logic                  rs_ovf;

    assign out_valid = vld[NUM_STAGE-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // The true product always fits in PW bits, so a PW-bit signed multiply is exact.
    always_comb begin
        a_ext  = {{(PW-DIN0_WIDTH){(SIGNED0 != 0) && din0[DIN0_WIDTH-1]}}, din0};
        b_ext  = {{(PW-DIN1_WIDTH){(SIGNED1 != 0) && din1[DIN1_WIDTH-1]}}, din1};
        prod_c = a_ext * b_ext;
    end

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign rs_prod = prod_c;
        end else begin : g_multi
            logic [PW-1:0] pipe [NUM_STAGE-1];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < NUM_STAGE - 1; i++) pipe[i] <= '0;
                end else if (adv) begin
                    pipe[0] <= prod_c;
                    for (int i = 1; i < NUM_STAGE - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign rs_prod = pipe[NUM_STAGE-2];
        end
    endgenerate

    shufflenetv2_mul_round_sat #(
        .PW         (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .RES_SIGNED (RES_SIGNED),
        .FRAC_BITS  (FRAC_BITS),
        .SATURATE   (SATURATE)
    ) u_round_sat (
        .prod (rs_prod),
        .dout (rs_dout),
        .ovf  (rs_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= '0;
            dout <= '0;
            ovf  <= 1'b0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) vld[i] <= vld[i-1];
            dout <= rs_dout;
            ovf  <= rs_ovf;
        end
    end

endmodule

// File: tb/tb_shufflenetv2_mul_pipe.sv
// Directed bench: defaults, signed rounding/saturation, stalls, mid-stream reset, single stage.
module tb_shufflenetv2_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // default configuration, 3 stages
    logic [11:0] a_d0;
    logic [9:0]  a_d1;
    logic        a_ivld, a_irdy, a_ovld, a_ordy, a_ovf;
    logic [21:0] a_dout;

    // 8x8 signed, 2 stages: s1 saturating, s2 truncating
    logic [7:0] s_d0, s_d1;
    logic       s_ivld, s_ordy;
    logic       s_irdy1, s_ovld1, s_ovf1;
    logic       s_irdy2, s_ovld2, s_ovf2;
    logic [7:0] s_dout1, s_dout2;

    // default widths, single stage
    logic [11:0] c_d0;
    logic [9:0]  c_d1;
    logic        c_ivld, c_irdy, c_ovld, c_ordy, c_ovf;
    logic [21:0] c_dout;

    shufflenetv2_mul_pipe u_a (
        .clk(clk), .reset(reset), .din0(a_d0), .din1(a_d1),
        .in_valid(a_ivld), .in_ready(a_irdy), .dout(a_dout), .ovf(a_ovf),
        .out_valid(a_ovld), .out_ready(a_ordy));

    shufflenetv2_mul_pipe #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(2),
        .SIGNED0(1), .SIGNED1(1), .FRAC_BITS(4), .SATURATE(1)
    ) u_s1 (
        .clk(clk), .reset(reset), .din0(s_d0), .din1(s_d1),
        .in_valid(s_ivld), .in_ready(s_irdy1), .dout(s_dout1), .ovf(s_ovf1),
        .out_valid(s_ovld1), .out_ready(s_ordy));

    shufflenetv2_mul_pipe #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(2),
        .SIGNED0(1), .SIGNED1(1), .FRAC_BITS(4), .SATURATE(0)
    ) u_s2 (
        .clk(clk), .reset(reset), .din0(s_d0), .din1(s_d1),
        .in_valid(s_ivld), .in_ready(s_irdy2), .dout(s_dout2), .ovf(s_ovf2),
        .out_valid(s_ovld2), .out_ready(s_ordy));

    shufflenetv2_mul_pipe #(.NUM_STAGE(1)) u_c (
        .clk(clk), .reset(reset), .din0(c_d0), .din1(c_d1),
        .in_valid(c_ivld), .in_ready(c_irdy), .dout(c_dout), .ovf(c_ovf),
        .out_valid(c_ovld), .out_ready(c_ordy));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sa [4] = '{8'd3, 8'd5, 8'hFD, 8'h80};
    logic [7:0] sb [4] = '{8'd3, 8'd5, 8'd3,  8'h80};
    logic [7:0] e1 [4] = '{8'd1, 8'd2, 8'hFF, 8'h7F};
    logic [7:0] e2 [4] = '{8'd1, 8'd2, 8'hFF, 8'h00};
    logic       o1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    int          expq [$];
    logic [31:0] pat = 32'hB5C3_9A6E;

    initial begin
        int sent, got, cyc;
        logic stall_prev;
        logic [21:0] held;

        reset = 1'b1;
        a_d0 = 12'd5; a_d1 = 10'd7; a_ivld = 1'b1; a_ordy = 1'b1;
        s_d0 = '0; s_d1 = '0; s_ivld = 1'b0; s_ordy = 1'b1;
        c_d0 = '0; c_d1 = '0; c_ivld = 1'b0; c_ordy = 1'b1;

        // reset state, with a beat presented on the reset edges
        step();
        step();
        chk("rst_ovld", a_ovld, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_irdy", a_irdy, 1);
        chk("rst_s_ovld", s_ovld1, 0);
        chk("rst_c_ovld", c_ovld, 0);
        reset = 1'b0;
        a_ivld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_drop", a_ovld, 0);
        end

        // full-scale unsigned product, exact latency
        a_d0 = 12'd4095; a_d1 = 10'd1023; a_ivld = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            a_ivld = 1'b0;
            chk("lat_ovld", a_ovld, (k == 3));
            if (k == 3) begin
                chk("lat_dout", a_dout, 64'd4189185);
                chk("lat_ovf", a_ovf, 0);
            end
        end

        // signed rounding with saturation and with truncation
        for (int j = 1; j <= 7; j++) begin
            s_ivld = (j <= 4);
            if (j <= 4) begin
                s_d0 = sa[j-1];
                s_d1 = sb[j-1];
            end
            step();
            chk("sgn_ovld1", s_ovld1, (j >= 2 && j <= 5));
            chk("sgn_ovld2", s_ovld2, (j >= 2 && j <= 5));
            if (j >= 2 && j <= 5) begin
                chk("sat_dout", s_dout1, e1[j-2]);
                chk("sat_ovf", s_ovf1, o1[j-2]);
                chk("trn_dout", s_dout2, e2[j-2]);
                chk("trn_ovf", s_ovf2, o1[j-2]);
            end
        end
        s_ivld = 1'b0;

        // single stage, alternating valid
        for (int i = 0; i < 10; i++) begin
            c_ivld = (i % 2 == 0) && (i < 8);
            c_d0 = 12'(100 + i * 37);
            c_d1 = 10'(3 + i * 50);
            step();
            chk("ns1_ovld", c_ovld, ((i % 2 == 0) && (i < 8)));
            if ((i % 2 == 0) && (i < 8))
                chk("ns1_dout", c_dout, 64'((100 + i * 37) * (3 + i * 50)));
        end
        c_ivld = 1'b0;

        // 16-beat stream with out_ready pattern
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while (got < 16 && cyc < 300) begin
            a_ivld = (sent < 16);
            a_d0 = 12'(sent * 257 + 3);
            a_d1 = 10'(sent * 61 + 5);
            a_ordy = pat[cyc % 32];
            #1;
            if (stall_prev) begin
                chk("stall_vld", a_ovld, 1);
                chk("stall_dat", a_dout, held);
            end
            if (a_ovld && !a_ordy) chk("stall_rdy", a_irdy, 0);
            if (a_ivld && a_irdy) begin
                expq.push_back(int'(a_d0) * int'(a_d1));
                sent++;
            end
            if (a_ovld && a_ordy) begin
                if (expq.size() == 0) chk("stream_extra", 1, 0);
                else chk("stream_dat", a_dout, 64'(expq.pop_front()));
                got++;
            end
            stall_prev = a_ovld && !a_ordy;
            held = a_dout;
            cyc++;
            step();
        end
        chk("stream_cnt", got, 16);
        a_ivld = 1'b0;
        a_ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stream_tail", a_ovld, 0);
        end

        // reset with two beats in flight
        a_ivld = 1'b1; a_d0 = 12'd11; a_d1 = 10'd13;
        step();
        a_d0 = 12'd17; a_d1 = 10'd19;
        step();
        a_ivld = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_rst_ovld", a_ovld, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_rst_drop", a_ovld, 0);
        end
        a_ivld = 1'b1; a_d0 = 12'd21; a_d1 = 10'd23;
        for (int k = 1; k <= 5; k++) begin
            step();
            a_ivld = 1'b0;
            chk("post_rst_ovld", a_ovld, (k == 3));
            if (k == 3) chk("post_rst_dout", a_dout, 64'd483);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
